// File: rtl/forwardpipe.sv
// forwardpipe: multi-stage forward-registered valid/ready pipeline.
// Valid/data are flopped per stage; ready ripples back so bubbles collapse.
module forwardpipe #(
    parameter int L     = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    output logic                       ready_f,
    input  logic                       valid_f,
    input  logic [L-1:0]               data_f,
    input  logic                       ready_b,
    output logic                       valid_b,
    output logic [L-1:0]               data_b,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] acc;
    logic [DEPTH-1:0] vin;
    logic [L-1:0]     d   [DEPTH];
    logic [L-1:0]     din [DEPTH];
    logic             in_x;
    logic             out_x;

    // A stage accepts when it is empty or everything ahead of it moves.
    always_comb begin
        acc = '0;
        acc[DEPTH-1] = ~v[DEPTH-1] | ready_b;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            acc[i] = ~v[i] | acc[i+1];
        end
    end

    always_comb begin
        vin    = '0;
        vin[0] = valid_f;
        din[0] = data_f;
        for (int i = 1; i < DEPTH; i++) begin
            vin[i] = v[i-1];
            din[i] = d[i-1];
        end
    end

    assign ready_f = acc[0] & ~flush;
    assign in_x    = valid_f & ready_f;
    assign out_x   = v[DEPTH-1] & ready_b & ~flush;
    assign valid_b = v[DEPTH-1];
    assign data_b  = d[DEPTH-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (acc[i]) v[i] <= vin[i];
            end
        end
    end

    // Bubbles leave the data flops untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else if (!flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (acc[i] && vin[i]) d[i] <= din[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (in_x && !out_x) begin
            count <= count + CW'(1);
        end else if (!in_x && out_x) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_forwardpipe.sv
// tb_forwardpipe: directed and randomized checks of forwardpipe (DEPTH=3).
// Reference model tracks each word's stage position in a queue.
module tb_forwardpipe;

    localparam int L     = 8;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          ready_f;
    logic          valid_f;
    logic [L-1:0]  data_f;
    logic          ready_b;
    logic          valid_b;
    logic [L-1:0]  data_b;
    logic [CW-1:0] count;

    int vectors     = 0;
    int miscompares = 0;

    byte unsigned mq_d[$];
    int           mq_p[$];

    always #5 clk = ~clk;

    forwardpipe #(.L(L), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .ready_f (ready_f),
        .valid_f (valid_f),
        .data_f  (data_f),
        .ready_b (ready_b),
        .valid_b (valid_b),
        .data_b  (data_b),
        .count   (count)
    );

    function automatic bit m_ready();
        return !flush && (mq_d.size() < DEPTH || ready_b);
    endfunction

    function automatic bit m_valid();
        return mq_p.size() > 0 && mq_p[0] == DEPTH - 1;
    endfunction

    // Words advance one stage if the stage ahead is (or becomes) free.
    function automatic void m_edge();
        bit take;
        int lim;
        if (flush) begin
            mq_d.delete();
            mq_p.delete();
            return;
        end
        take = valid_f && m_ready();
        if (m_valid() && ready_b) begin
            void'(mq_d.pop_front());
            void'(mq_p.pop_front());
        end
        lim = DEPTH - 1;
        foreach (mq_p[k]) begin
            mq_p[k] = (mq_p[k] + 1 < lim) ? mq_p[k] + 1 : lim;
            lim = mq_p[k] - 1;
        end
        if (take) begin
            mq_d.push_back(data_f);
            mq_p.push_back(0);
        end
    endfunction

    task automatic tick();
        m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        flush   = 1'b0;
        valid_f = 1'b0;
        ready_b = 1'b1;
        for (int i = 0; i < 8 && mq_d.size() > 0; i++) tick();
        @(negedge clk);
        vectors++;
        if (count !== '0 || valid_b !== 1'b0) begin
            miscompares++;
            $display("FAIL drain: got cnt=%0d v=%b, want cnt=0 v=0",
                     count, valid_b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; valid_f = 1'b0;
        data_f = '0; ready_b = 1'b0;
        #1 rst = 1'b0;
        #2;
        vectors++;
        if (valid_b !== 1'b0 || data_b !== '0 ||
            count !== '0 || ready_f !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: got v=%b d=%h cnt=%0d rdy=%b, want 0 00 0 1",
                     valid_b, data_b, count, ready_f);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int e_c;
        bit e_v;
        logic [7:0] e_d;
        ready_b = 1'b1;
        for (int c = 0; c < 7; c++) begin
            valid_f = (c < 3);
            data_f  = 8'(8'h11 * (c + 1));
            @(negedge clk);
            e_v = (c >= 3 && c <= 5);
            e_d = 8'(8'h11 * (c - 2));
            e_c = (c <= 3) ? c : 6 - c;
            vectors++;
            if (ready_f !== 1'b1 || valid_b !== e_v ||
                (e_v && data_b !== e_d) || count !== CW'(e_c)) begin
                miscompares++;
                $display("FAIL b2b c=%0d: got rdy=%b v=%b d=%h cnt=%0d, want rdy=1 v=%b d=%h cnt=%0d",
                         c, ready_f, valid_b, data_b, count, e_v, e_d, e_c);
            end
            tick();
        end
    endtask

    task automatic test_full_stall();
        int e_r[10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        int e_v[10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
        int e_d[10] = '{0, 0, 0, 'hA0, 'hA0, 'hA0, 'hA1, 'hA2, 'hA3, 0};
        int e_c[10] = '{0, 1, 2, 3, 3, 3, 3, 2, 1, 0};
        for (int c = 0; c < 10; c++) begin
            valid_f = (c <= 5);
            data_f  = (c < 3) ? 8'(8'hA0 + c) : 8'hA3;
            ready_b = (c >= 5);
            @(negedge clk);
            vectors++;
            if (ready_f !== e_r[c][0] || valid_b !== e_v[c][0] ||
                (e_v[c] != 0 && data_b !== 8'(e_d[c])) ||
                count !== CW'(e_c[c])) begin
                miscompares++;
                $display("FAIL full c=%0d: got rdy=%b v=%b d=%h cnt=%0d, want rdy=%0d v=%0d d=%h cnt=%0d",
                         c, ready_f, valid_b, data_b, count,
                         e_r[c], e_v[c], 8'(e_d[c]), e_c[c]);
            end
            tick();
        end
    endtask

    task automatic test_bubble();
        int e_v[9] = '{0, 0, 0, 1, 1, 1, 1, 1, 0};
        int e_d[9] = '{0, 0, 0, 1, 1, 1, 2, 3, 0};
        int e_c[9] = '{0, 1, 1, 1, 2, 3, 2, 1, 0};
        for (int c = 0; c < 9; c++) begin
            valid_f = (c == 0 || c == 3 || c == 4);
            data_f  = (c == 0) ? 8'h01 : (c == 3) ? 8'h02 : 8'h03;
            ready_b = (c >= 5);
            @(negedge clk);
            vectors++;
            if (ready_f !== 1'b1 || valid_b !== e_v[c][0] ||
                (e_v[c] != 0 && data_b !== 8'(e_d[c])) ||
                count !== CW'(e_c[c])) begin
                miscompares++;
                $display("FAIL bubble c=%0d: got rdy=%b v=%b d=%h cnt=%0d, want rdy=1 v=%0d d=%h cnt=%0d",
                         c, ready_f, valid_b, data_b, count,
                         e_v[c], 8'(e_d[c]), e_c[c]);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        int e_r[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
        int e_v[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        int e_c[8] = '{0, 1, 2, 3, 0, 0, 0, 0};
        for (int c = 0; c < 8; c++) begin
            flush   = (c == 3);
            valid_f = (c <= 3);
            data_f  = (c < 3) ? 8'(8'hB1 + c) : 8'hEE;
            ready_b = (c >= 4);
            @(negedge clk);
            vectors++;
            if (ready_f !== e_r[c][0] || valid_b !== e_v[c][0] ||
                (e_v[c] != 0 && data_b !== 8'hB1) ||
                count !== CW'(e_c[c])) begin
                miscompares++;
                $display("FAIL flush c=%0d: got rdy=%b v=%b d=%h cnt=%0d, want rdy=%0d v=%0d cnt=%0d",
                         c, ready_f, valid_b, data_b, count,
                         e_r[c], e_v[c], e_c[c]);
            end
            tick();
        end
        flush = 1'b0;
    endtask

    task automatic test_random();
        byte unsigned nxt_in  = 8'h00;
        byte unsigned nxt_out = 8'h00;
        bit take;
        for (int c = 0; c < 1000; c++) begin
            flush   = 1'b0;
            valid_f = ($urandom_range(0, 99) < 60);
            ready_b = ($urandom_range(0, 99) < 50);
            data_f  = nxt_in;
            @(negedge clk);
            vectors++;
            if (ready_f !== m_ready() || valid_b !== m_valid() ||
                (m_valid() && data_b !== mq_d[0]) ||
                count !== CW'(mq_d.size())) begin
                miscompares++;
                $display("FAIL rand c=%0d: got rdy=%b v=%b d=%h cnt=%0d, want rdy=%b v=%b cnt=%0d",
                         c, ready_f, valid_b, data_b, count,
                         m_ready(), m_valid(), mq_d.size());
            end
            if (valid_b === 1'b1 && ready_b) begin
                vectors++;
                if (data_b !== nxt_out) begin
                    miscompares++;
                    $display("FAIL order c=%0d: got d=%h, want d=%h",
                             c, data_b, nxt_out);
                end
                nxt_out++;
            end
            take = valid_f && m_ready();
            tick();
            if (take) nxt_in++;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        flush = 1'b0;
        ready_b = 1'b0;
        for (int c = 0; c < 3; c++) begin
            valid_f = 1'b1;
            data_f  = 8'(8'hC1 + c);
            tick();
        end
        ready_b = 1'b1;
        valid_f = 1'b1;
        data_f  = 8'hC4;
        #1 rst = 1'b0;
        #1;
        vectors++;
        if (valid_b !== 1'b0 || data_b !== '0 ||
            count !== '0 || ready_f !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid: got v=%b d=%h cnt=%0d rdy=%b, want 0 00 0 1",
                     valid_b, data_b, count, ready_f);
        end
        mq_d.delete();
        mq_p.delete();
        valid_f = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            valid_f = (c == 0);
            data_f  = 8'hD1;
            @(negedge clk);
            vectors++;
            if (ready_f !== 1'b1 || valid_b !== (c == 3) ||
                (c == 3 && data_b !== 8'hD1)) begin
                miscompares++;
                $display("FAIL rst_after c=%0d: got rdy=%b v=%b d=%h, want rdy=1 v=%b d=d1",
                         c, ready_f, valid_b, data_b, (c == 3));
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_full_stall();
        test_bubble();
        test_flush();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/forwardpipe.md
Name: forwardpipe

Overview:
- Multi-stage forward-registered valid/ready pipeline.
- Companion to the team's backward (ready-registered) pipe: this block registers the valid/data path, so downstream sees clean flop outputs for timing.
- Ready propagates combinationally from the back stage to the front stage, and empty stages accept new data even when the output is stalled (bubble collapse).
- Sits between producer and consumer stages on long valid/data routes. Chain it with the backward pipe to make a fully registered slice.

Parameters:
- L, 8, data width in bits.
- DEPTH, 2, number of register stages; legal range 1..16.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset: asynchronous, active-low.
- flush  input  1  synchronous clear of all stages.
- ready_f  output  1  upstream ready (combinational).
- valid_f  input  1  upstream valid.
- data_f  input  L  upstream data.
- ready_b  input  1  downstream ready.
- valid_b  output  1  downstream valid (registered).
- data_b  output  L  downstream data (registered).
- count  output  $clog2(DEPTH+1)  number of occupied stages.

Behaviour:
- Stage numbering: stage 0 is nearest the input, stage DEPTH-1 drives valid_b/data_b. Each stage has a flop v[i] and a flop d[i] of L bits.
- Reset (rst=0, asynchronous): all v[i]=0 and all d[i]=0, giving valid_b=0, data_b=0, count=0, ready_f=1 immediately.
- Stage acceptance term acc[i] = ~v[i] | nxt[i], with nxt[DEPTH-1]=ready_b and nxt[i]=acc[i+1] for i<DEPTH-1.
- ready_f = acc[0] & ~flush.
- Input transfer occurs when valid_f & ready_f. Output transfer occurs when valid_b & ready_b & ~flush.
- Per-edge update, when flush=0 and acc[i]=1:
  - v[0] <= valid_f; v[i] <= v[i-1] for i>0.
  - d[i] loads only when the incoming valid is 1; otherwise d[i] holds.
  - Bubbles carry no data update.
- When acc[i]=0, the stage holds v[i] and d[i].
- Latency: DEPTH cycles from input transfer to valid_b=1 when empty and unstalled. Throughput: 1 word per cycle when ready_b=1.
- Stability: while valid_b=1 and ready_b=0, valid_b and data_b stay constant. Order is strictly preserved; no drop, no duplication.
- Full condition: all v[i]=1 and ready_b=0 gives ready_f=0.
- Full with ready_b=1: ready_f=1, a simultaneous in/out transfer occurs, and count is unchanged.
- Bubble collapse: with ready_b=0, any empty stage k lets stages 0..k advance that cycle.
- Flush: the edge with flush=1 clears all v[i] and leaves d[i] unchanged.
  - During the flush cycle, ready_f=0 and no input transfer is counted.
  - valid_b still shows its register value, but the consumer must treat that cycle as no transfer.
  - flush has priority over all other updates.
- count is registered and equals the popcount of v[]. It updates by +1, -1, 0, or to 0 on flush each edge, and never exceeds DEPTH.
- Reset asserted mid-stream discards all contents immediately. After release, ready_f=1 and no stale valid_b appears.
- DEPTH=1 degenerates to a single forward register: ready_f = ~v[0] | ready_b.

Test Plan:
- L=8, DEPTH=3, ready_b=1; send 0x11,0x22,0x33 back-to-back from cycle 0 -> valid_b=1 from cycle 3 with data_b 0x11,0x22,0x33 in consecutive cycles; count peaks at 3; ready_f stays 1.
- ready_b=0; send 0xA0..0xA3 -> 0xA0..0xA2 accepted; ready_f=0 on the 4th attempt; count=3; data_b=0xA0 stable. Raise ready_b for 1 cycle -> 0xA0 transfers, 0xA3 is accepted in the same cycle, count stays 3.
- Bubble collapse: load 0x01 only, ready_b=0 -> it reaches stage 2 after 3 cycles; then send 0x02,0x03 -> both accepted (count=3) while valid_b holds 0x01.
- Random valid_f/ready_b over 1000 cycles with incrementing data -> output sequence equals input sequence, no gaps or repeats, and count matches a scoreboard every cycle.
- Fill with 3 words, pulse flush=1 for 1 cycle with valid_f=1 -> ready_f=0 during the pulse; next cycle valid_b=0, count=0, ready_f=1; the flushed-cycle input is not delivered.
- Assert rst low asynchronously mid-transfer with the pipe full -> valid_b=0, data_b=0x00, count=0, ready_f=1 before the next clk edge; after release, the first new word emerges after 3 cycles.
